// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1RW+1R self-clearing SRAM macro.
package sram_pkg;

  typedef enum logic {StClear, StReady} state_e;

  // Widest word lane_merge handles; callers widen into and truncate out of this.
  localparam int unsigned MaxWidth = 256;

  // Bitwise merge: bits set in bit_mask come from new_word, the rest from old_word.
  function automatic logic [MaxWidth-1:0] lane_merge(input logic [MaxWidth-1:0] old_word,
                                                     input logic [MaxWidth-1:0] new_word,
                                                     input logic [MaxWidth-1:0] bit_mask);
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/sram_1rw1r_clr_if.sv
// Access bus of sram_1rw1r_clr: port0 read/write, port1 read, clear request and status.
interface sram_1rw1r_clr_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_WMASKS = 4
);
  logic                  clr0;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  init_busy;
  logic                  collision;

  modport master (
    output clr0, csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, init_busy, collision
  );

  modport slave (
    input  clr0, csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, init_busy, collision
  );
endinterface

// File: rtl/sram_clr_fsm.sv
// Clear engine: sweeps every address once after reset or clr0, masking chip selects meanwhile.
module sram_clr_fsm
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  clr0,
  input  logic                  csb0,
  input  logic                  csb1,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_ptr,
  output logic                  csb0_gated,
  output logic                  csb1_gated
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        if (ptr_q == LastAddr) begin
          state_d = StReady;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      StReady: begin
        if (clr0) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    init_busy  = (state_q == StClear);
    clr_we     = init_busy;
    clr_ptr    = ptr_q;
    csb0_gated = csb0 | init_busy;
    csb1_gated = csb1 | init_busy;
  end

endmodule

// File: rtl/sram_1rw1r_clr.sv
// Parametrised 1RW+1R SRAM with self-clearing init and collision flag.
// Define SRAM_FWD_EN to forward port0 write data to a colliding port1 read.
module sram_1rw1r_clr
  import sram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           WMASK_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input logic              clk0,
  input logic              rstb0,
  sram_1rw1r_clr_if.slave  bus
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  clr_we, csb0_gated, csb1_gated, init_busy;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] bit_mask, merged, rd1_data;
  logic                  wr_en, rd0_en, rd1_en, collide;
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
  logic                  collision_q;

  sram_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_fsm (
    .clk0       (clk0),
    .rstb0      (rstb0),
    .clr0       (bus.clr0),
    .csb0       (bus.csb0),
    .csb1       (bus.csb1),
    .init_busy  (init_busy),
    .clr_we     (clr_we),
    .clr_ptr    (clr_ptr),
    .csb0_gated (csb0_gated),
    .csb1_gated (csb1_gated)
  );

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      bit_mask[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{bus.wmask0[i]}};
    end
  end

  always_comb begin
    wr_en   = !csb0_gated && !bus.web0;
    rd0_en  = !csb0_gated && bus.web0;
    rd1_en  = !csb1_gated;
    collide = wr_en && rd1_en && (bus.addr0 == bus.addr1);
    merged  = DATA_WIDTH'(lane_merge(MaxWidth'(mem[bus.addr0]), MaxWidth'(bus.din0),
                                     MaxWidth'(bit_mask)));
`ifdef SRAM_FWD_EN
    rd1_data = collide ? merged : mem[bus.addr1];
`else
    rd1_data = mem[bus.addr1];
`endif
  end

  // Array contents are deliberately not reset; the clear engine initialises them.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem[clr_ptr] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[bus.addr0] <= merged;
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      dout0_q     <= '0;
      dout1_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      if (rd0_en) dout0_q <= mem[bus.addr0];
      if (rd1_en) dout1_q <= rd1_data;
      collision_q <= collide;
    end
  end

  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;
  assign bus.collision = collision_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_sram_1rw1r_clr.sv
// Directed self-checking bench for sram_1rw1r_clr (default parameters).
module tb_sram_1rw1r_clr;

  logic clk0 = 1'b0;
  logic rstb0;
  int   ncmp  = 0;
  int   nfail = 0;
  int   cnt;

  always #5 clk0 = ~clk0;

  sram_1rw1r_clr_if #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .NUM_WMASKS (4)
  ) bus ();

  sram_1rw1r_clr dut (
    .clk0  (clk0),
    .rstb0 (rstb0),
    .bus   (bus)
  );

`ifdef SRAM_FWD_EN
  localparam logic [31:0] CollExp = 32'h1111_1111;
`else
  localparam logic [31:0] CollExp = 32'h0000_0000;
`endif

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.clr0   = 1'b0;
    bus.csb0   = 1'b1;
    bus.web0   = 1'b1;
    bus.wmask0 = '0;
    bus.csb1   = 1'b1;
  endtask

  task automatic write0(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.csb0   = 1'b0;
    bus.web0   = 1'b0;
    bus.addr0  = a;
    bus.din0   = d;
    bus.wmask0 = m;
  endtask

  task automatic read0(input logic [9:0] a);
    bus.csb0  = 1'b0;
    bus.web0  = 1'b1;
    bus.addr0 = a;
  endtask

  task automatic read1(input logic [9:0] a);
    bus.csb1  = 1'b0;
    bus.addr1 = a;
  endtask

  task automatic count_busy();
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rstb0     = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.din0  = '0;
    idle();
    #2;
    check("rst_dout0", bus.dout0, 32'h0);
    check("rst_dout1", bus.dout1, 32'h0);
    check("rst_busy", {31'b0, bus.init_busy}, 32'h1);
    check("rst_coll", {31'b0, bus.collision}, 32'h0);

    #10 rstb0 = 1'b1;
    count_busy();
    check("clear_cycles", cnt, 32'd1024);

    // Busy just dropped: this access is accepted.
    read0(10'h3FF);
    tick(); idle();
    check("rd_3ff", bus.dout0, 32'h0);

    write0(10'h010, 32'hDEAD_BEEF, 4'hF);
    tick();
    write0(10'h010, 32'h0000_5500, 4'h2);
    tick(); idle();
    read1(10'h010);
    tick(); idle();
    check("mask_merge", bus.dout1, 32'hDEAD_55EF);

    write0(10'h020, 32'h1111_1111, 4'hF);
    read1(10'h020);
    tick(); idle();
    check("coll_flag", {31'b0, bus.collision}, 32'h1);
    check("coll_dout1", bus.dout1, CollExp);
    tick();
    check("coll_pulse", {31'b0, bus.collision}, 32'h0);
    read0(10'h020);
    tick(); idle();
    check("coll_written", bus.dout0, 32'h1111_1111);

    write0(10'h030, 32'h3333_3333, 4'hF);
    read1(10'h010);
    tick(); idle();
    check("nocoll_flag", {31'b0, bus.collision}, 32'h0);
    check("nocoll_dout1", bus.dout1, 32'hDEAD_55EF);

    write0(10'h010, 32'hFFFF_FFFF, 4'h0);
    tick(); idle();
    read0(10'h010);
    tick(); idle();
    check("mask0_noop", bus.dout0, 32'hDEAD_55EF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_dout0", bus.dout0, 32'hDEAD_55EF);
    end

    bus.clr0 = 1'b1;
    tick();
    bus.clr0 = 1'b0;
    // Accesses during the sweep must be ignored.
    write0(10'h010, 32'hAAAA_AAAA, 4'hF);
    read1(10'h030);
    count_busy();
    idle();
    check("reclear_cycles", cnt, 32'd1024);
    check("reclear_hold0", bus.dout0, 32'hDEAD_55EF);
    check("reclear_hold1", bus.dout1, 32'hDEAD_55EF);
    read0(10'h010);
    read1(10'h020);
    tick(); idle();
    check("reclear_010", bus.dout0, 32'h0);
    check("reclear_020", bus.dout1, 32'h0);

    write0(10'h040, 32'h1234_5678, 4'hF);
    tick(); idle();
    read0(10'h040);
    read1(10'h040);
    tick(); idle();
    check("pre_rst_dout0", bus.dout0, 32'h1234_5678);

    bus.clr0 = 1'b1;
    tick();
    bus.clr0 = 1'b0;
    repeat (500) tick();
    check("mid_busy", {31'b0, bus.init_busy}, 32'h1);
    rstb0 = 1'b0;
    #1;
    check("mid_rst_dout0", bus.dout0, 32'h0);
    check("mid_rst_dout1", bus.dout1, 32'h0);
    #3 rstb0 = 1'b1;
    count_busy();
    check("restart_cycles", cnt, 32'd1024);
    read0(10'h040);
    tick(); idle();
    check("final_040", bus.dout0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
